// File: rtl/ram_wr_gen.sv
// RAM write-pattern generator: emits a burst of write beats with a programmable
// start address, length and data pattern, honouring sink back-pressure.
module ram_wr_gen #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              wr_ready_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W:0]   DepthLen = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   OneLen   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e            state_q;
  logic [1:0]        mode_q;
  logic [ADDR_W:0]   remaining_q;
  logic              wr_en_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic [ADDR_W-1:0] base_eff;
  logic [ADDR_W:0]   len_eff;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;

  // Condition request operands: out-of-range base starts at 0, length clamps to DEPTH.
  always_comb begin
    base_eff = ({1'b0, base_addr_i} >= DepthLen) ? '0 : base_addr_i;
    len_eff  = (len_i > DepthLen) ? DepthLen : len_i;
  end

  // Next beat address (wraps at DEPTH, not at 2^ADDR_W) and next pattern word.
  always_comb begin
    addr_d = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
    data_d = data_q;
    case (mode_q)
      2'd0:    data_d = data_q + 1'b1;
      2'd1:    data_d = data_q - 1'b1;
      2'd2:    data_d = data_q;
      default: data_d = {data_q[DATA_W-2:0], data_q[DATA_W-1]};
    endcase
  end

  // Burst FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= 2'd0;
      remaining_q <= '0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start_i) begin
            mode_q      <= mode_i;
            addr_q      <= base_eff;
            data_q      <= seed_i;
            remaining_q <= len_eff;
            if (len_eff != '0) begin
              state_q <= StWrite;
              wr_en_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StWrite: begin
          // Beat is consumed only when the sink accepts; otherwise hold everything.
          if (wr_ready_i) begin
            remaining_q <= remaining_q - 1'b1;
            addr_q      <= addr_d;
            data_q      <= data_d;
            if (remaining_q == OneLen) begin
              state_q <= StDone;
              wr_en_q <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = addr_q;
  assign wr_data_o = data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule
